// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU command sequencer: widths, ALU opcodes,
// sequencer state encoding and the latched command record.
package alu_pkg;

    localparam int ALU_W  = 4;
    localparam int NREGS  = 4;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 2;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [OP_W-1:0] ALU_AND = 3'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 3'd4;
    localparam logic [OP_W-1:0] ALU_NOT = 3'd5;
    localparam logic [OP_W-1:0] ALU_SHL = 3'd6;
    localparam logic [OP_W-1:0] ALU_SHR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Only the fields still needed after acceptance; load data goes straight
    // to the register file and tmp.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] dst;
        logic [ADDR_W-1:0] src_a;
        logic [ADDR_W-1:0] src_b;
        logic [CNT_W-1:0]  cnt;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle between a host (master) and the
// ALU command sequencer (slave).
interface alu_cmd_sequencer_if;
    import alu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_load;
    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W-1:0] cmd_src_a;
    logic [ADDR_W-1:0] cmd_src_b;
    logic [CNT_W-1:0]  cmd_cnt;
    logic [ALU_W-1:0]  cmd_imm;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ALU_W-1:0]  rsp_data;
    logic              rsp_carry;

    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b,
               cmd_cnt, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_carry
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b,
               cmd_cnt, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_carry
    );

endinterface

// File: rtl/alu_regfile.sv
// 4x4-bit register file: two combinational read ports, one synchronous write
// port, every entry cleared by the asynchronous reset.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ALU_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [ALU_W-1:0]  rdata_a,
    output logic [ALU_W-1:0]  rdata_b
);

    logic [ALU_W-1:0] regs [NREGS];

    // NOTE: this array is reset on purpose -- an aborted command must leave every
    // register at zero, so it is built from flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side initiator for the external 4-bit ALU: accepts load/operate
// commands, iterates the ALU up to four passes and returns result plus sticky carry.
module alu_cmd_sequencer
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    alu_cmd_sequencer_if.slave  bus,
    output logic [ALU_W-1:0]    alu_a,
    output logic [ALU_W-1:0]    alu_b,
    output logic [OP_W-1:0]     alu_opcode,
    input  logic [ALU_W-1:0]    alu_result,
    input  logic                alu_carry
);

    state_t            state;
    cmd_t              cur;
    logic [CNT_W-1:0]  iter;
    logic [ALU_W-1:0]  tmp;
    logic              carry;

    logic              accept;
    logic              last_pass;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [ALU_W-1:0]  rf_wdata;
    logic [ALU_W-1:0]  rd_a;
    logic [ALU_W-1:0]  rd_b;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = tmp;
    assign bus.rsp_carry = carry;

    assign accept    = bus.cmd_valid && (state == IDLE);
    assign last_pass = (state == EXEC) && (iter == cur.cnt);

    alu_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (cur.src_a),
        .raddr_b (cur.src_b),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    // NOTE: every output of this block gets a default first, so no path through
    // the if/else can leave a value held and infer a latch.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = cur.dst;
        rf_wdata = alu_result;
        if (accept && bus.cmd_load) begin
            rf_we    = 1'b1;
            rf_waddr = bus.cmd_dst;
            rf_wdata = bus.cmd_imm;
        end else if (last_pass) begin
            rf_we    = 1'b1;
        end
    end

    // Later passes chain on tmp for A; B always comes from the register file,
    // which is not written until the final pass.
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        if (state == EXEC) begin
            alu_opcode = cur.op;
            alu_a      = (iter == '0) ? rd_a : tmp;
            alu_b      = rd_b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= '0;
            iter  <= '0;
            tmp   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur   <= '{op:    bus.cmd_op,
                                   dst:   bus.cmd_dst,
                                   src_a: bus.cmd_src_a,
                                   src_b: bus.cmd_src_b,
                                   cnt:   bus.cmd_cnt};
                        iter  <= '0;
                        carry <= 1'b0;
                        if (bus.cmd_load) begin
                            tmp   <= bus.cmd_imm;
                            state <= RESP;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    tmp   <= alu_result;
                    carry <= carry | alu_carry;
                    iter  <= iter + 1'b1;
                    if (last_pass) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: directed scenarios plus randomized commands compared
// against a pass-by-pass behavioural model of the register file.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_opcode;
    logic [3:0] alu_result;
    logic       alu_carry;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_carry  (alu_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    // Reference ALU, used both as the external ALU and inside the model.
    function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic       c;
        c = 1'b0;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: begin r = a - b; c = (a < b); end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_NOT: r = ~a;
            ALU_SHL: r = a << 1;
            ALU_SHR: r = a >> 1;
            default: r = 4'h0;
        endcase
        return {c, r};
    endfunction

    always_comb {alu_carry, alu_result} = alu_f(alu_opcode, alu_a, alu_b);

    logic [3:0] regs_m [4];
    logic [3:0] exp_d, obs_d;
    logic       exp_c, obs_c;
    int         exp_lat, obs_lat;
    logic       obs_acc, obs_stable, obs_busy, obs_ready_after;
    logic [3:0] exp_a [$];
    logic [3:0] obs_a [$];

    task automatic model_cmd(input logic load, input logic [2:0] op, input logic [1:0] dst,
                             input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] cnt,
                             input logic [3:0] imm);
        logic [3:0] t, a;
        logic [4:0] r;
        logic       c;
        exp_a.delete();
        if (load) begin
            regs_m[dst] = imm;
            exp_d = imm;
            exp_c = 1'b0;
            exp_lat = 1;
        end else begin
            t = 4'h0;
            c = 1'b0;
            for (int i = 0; i <= int'(cnt); i++) begin
                a = (i == 0) ? regs_m[sa] : t;
                r = alu_f(op, a, regs_m[sb]);
                exp_a.push_back(a);
                t = r[3:0];
                c = c | r[4];
            end
            regs_m[dst] = t;
            exp_d = t;
            exp_c = c;
            exp_lat = int'(cnt) + 2;
        end
    endtask

    // Drives one command and gathers observations; hold > 0 keeps rsp_ready low
    // that many extra cycles while presenting a stray load that must be ignored.
    task automatic do_cmd(input logic load, input logic [2:0] op, input logic [1:0] dst,
                          input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] cnt,
                          input logic [3:0] imm, input int hold);
        @(negedge clk);
        obs_acc = bus.cmd_ready;
        bus.cmd_load  = load;
        bus.cmd_op    = op;
        bus.cmd_dst   = dst;
        bus.cmd_src_a = sa;
        bus.cmd_src_b = sb;
        bus.cmd_cnt   = cnt;
        bus.cmd_imm   = imm;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (hold > 0) begin
            bus.cmd_load = 1'b1;
            bus.cmd_dst  = 2'd3;
            bus.cmd_imm  = 4'hF;
        end else begin
            bus.cmd_valid = 1'b0;
        end
        obs_lat = 1;
        obs_a.delete();
        while (!bus.rsp_valid && obs_lat < 16) begin
            obs_a.push_back(alu_a);
            @(negedge clk);
            obs_lat++;
        end
        obs_d = bus.rsp_data;
        obs_c = bus.rsp_carry;
        obs_stable = 1'b1;
        obs_busy = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (bus.cmd_ready) obs_busy = 1'b1;
            @(negedge clk);
            if (bus.rsp_data !== obs_d || bus.rsp_carry !== obs_c || bus.rsp_valid !== 1'b1)
                obs_stable = 1'b0;
        end
        if (bus.cmd_ready) obs_busy = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        obs_ready_after = bus.cmd_ready;
    endtask

    task automatic run_cmd(input logic load, input logic [2:0] op, input logic [1:0] dst,
                           input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] cnt,
                           input logic [3:0] imm, input int hold);
        model_cmd(load, op, dst, sa, sb, cnt, imm);
        do_cmd(load, op, dst, sa, sb, cnt, imm, hold);
    endtask

    task automatic readback(input logic [1:0] r);
        run_cmd(1'b0, ALU_OR, r, r, r, 2'd0, 4'h0, 0);
    endtask

    task automatic test_reset;
        bus.cmd_valid = 1'b0; bus.cmd_load = 1'b0; bus.cmd_op = 3'd0;
        bus.cmd_dst = 2'd0; bus.cmd_src_a = 2'd0; bus.cmd_src_b = 2'd0;
        bus.cmd_cnt = 2'd0; bus.cmd_imm = 4'h0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) regs_m[i] = 4'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        tests_run++;
        if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        tests_run++;
        if ({alu_a, alu_b, alu_opcode} !== 11'd0) begin tests_failed++; $display("FAIL reset_alu: got a=%h b=%h op=%h want 0", alu_a, alu_b, alu_opcode); end
    endtask

    task automatic test_load_sub;
        run_cmd(1'b1, ALU_ADD, 2'd0, 2'd0, 2'd0, 2'd0, 4'h5, 0);
        tests_run++;
        if (obs_d !== 4'h5 || obs_lat != 1 || obs_acc !== 1'b1) begin tests_failed++; $display("FAIL load_r0: got d=%h lat=%0d acc=%b want 5 1 1", obs_d, obs_lat, obs_acc); end
        run_cmd(1'b1, ALU_ADD, 2'd1, 2'd0, 2'd0, 2'd0, 4'h3, 0);
        run_cmd(1'b0, ALU_SUB, 2'd2, 2'd0, 2'd1, 2'd0, 4'h0, 0);
        tests_run++;
        if (obs_d !== 4'h2 || obs_c !== 1'b0) begin tests_failed++; $display("FAIL sub_5_3: got d=%h c=%b want 2 0", obs_d, obs_c); end
        tests_run++;
        if (obs_lat != 2) begin tests_failed++; $display("FAIL sub_latency: got %0d want 2", obs_lat); end
        run_cmd(1'b0, ALU_OR, 2'd3, 2'd2, 2'd2, 2'd0, 4'h0, 0);
        tests_run++;
        if (obs_d !== 4'h2) begin tests_failed++; $display("FAIL read_r2: got %h want 2", obs_d); end
    endtask

    task automatic test_sub_borrow;
        run_cmd(1'b0, ALU_SUB, 2'd2, 2'd1, 2'd0, 2'd0, 4'h0, 0);
        tests_run++;
        if (obs_d !== 4'hE || obs_c !== 1'b1) begin tests_failed++; $display("FAIL sub_3_5: got d=%h c=%b want e 1", obs_d, obs_c); end
    endtask

    task automatic test_shl_iter;
        run_cmd(1'b1, ALU_ADD, 2'd0, 2'd0, 2'd0, 2'd0, 4'h1, 0);
        run_cmd(1'b0, ALU_SHL, 2'd0, 2'd0, 2'd0, 2'd2, 4'h0, 0);
        tests_run++;
        if (obs_a.size() != 3) begin tests_failed++; $display("FAIL shl_pass_count: got %0d want 3", obs_a.size()); end
        else begin
            tests_run++;
            if (obs_a[0] !== 4'h1 || obs_a[1] !== 4'h2 || obs_a[2] !== 4'h4) begin
                tests_failed++; $display("FAIL shl_alu_a: got %h %h %h want 1 2 4", obs_a[0], obs_a[1], obs_a[2]);
            end
        end
        tests_run++;
        if (obs_d !== 4'h8 || obs_lat != 4) begin tests_failed++; $display("FAIL shl_result: got d=%h lat=%0d want 8 4", obs_d, obs_lat); end
        readback(2'd0);
        tests_run++;
        if (obs_d !== 4'h8) begin tests_failed++; $display("FAIL shl_writeback: got %h want 8", obs_d); end
    endtask

    task automatic test_add_iter;
        run_cmd(1'b1, ALU_ADD, 2'd0, 2'd0, 2'd0, 2'd0, 4'h9, 0);
        run_cmd(1'b1, ALU_ADD, 2'd1, 2'd0, 2'd0, 2'd0, 4'h9, 0);
        run_cmd(1'b0, ALU_ADD, 2'd1, 2'd0, 2'd1, 2'd1, 4'h0, 0);
        tests_run++;
        if (obs_d !== 4'hB || obs_c !== 1'b0 || obs_lat != 3) begin tests_failed++; $display("FAIL add_iter: got d=%h c=%b lat=%0d want b 0 3", obs_d, obs_c, obs_lat); end
    endtask

    task automatic test_backpressure;
        run_cmd(1'b1, ALU_ADD, 2'd3, 2'd0, 2'd0, 2'd0, 4'h6, 0);
        run_cmd(1'b0, ALU_SUB, 2'd2, 2'd1, 2'd0, 2'd0, 4'h0, 5);
        tests_run++;
        if (obs_d !== exp_d || obs_c !== exp_c) begin tests_failed++; $display("FAIL bp_result: got d=%h c=%b want %h %b", obs_d, obs_c, exp_d, exp_c); end
        tests_run++;
        if (obs_stable !== 1'b1) begin tests_failed++; $display("FAIL bp_stable: got %b want 1", obs_stable); end
        tests_run++;
        if (obs_busy !== 1'b0) begin tests_failed++; $display("FAIL bp_cmd_ready_low: got %b want 0", obs_busy); end
        tests_run++;
        if (obs_ready_after !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_after_release: got %b want 1", obs_ready_after); end
        readback(2'd3);
        tests_run++;
        if (obs_d !== 4'h6) begin tests_failed++; $display("FAIL bp_stray_ignored: got r3=%h want 6", obs_d); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            run_cmd(1'($urandom_range(3, 0) == 0), 3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)),
                    2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
                    4'($urandom_range(15, 0)), $urandom_range(2, 0));
            tests_run++;
            if (obs_d !== exp_d || obs_c !== exp_c || obs_lat != exp_lat || obs_acc !== 1'b1) begin
                tests_failed++;
                $display("FAIL rand_%0d: got d=%h c=%b lat=%0d acc=%b want %h %b %0d 1", n, obs_d, obs_c, obs_lat, obs_acc, exp_d, exp_c, exp_lat);
            end
            tests_run++;
            if (obs_a.size() != exp_a.size()) begin
                tests_failed++; $display("FAIL rand_%0d_passes: got %0d want %0d", n, obs_a.size(), exp_a.size());
            end else begin
                for (int i = 0; i < exp_a.size(); i++) begin
                    tests_run++;
                    if (obs_a[i] !== exp_a[i]) begin tests_failed++; $display("FAIL rand_%0d_alu_a[%0d]: got %h want %h", n, i, obs_a[i], exp_a[i]); end
                end
            end
        end
        for (int r = 0; r < 4; r++) begin
            readback(2'(r));
            tests_run++;
            if (obs_d !== exp_d) begin tests_failed++; $display("FAIL rand_final_r%0d: got %h want %h", r, obs_d, exp_d); end
        end
    endtask

    task automatic test_reset_mid_exec;
        run_cmd(1'b1, ALU_ADD, 2'd0, 2'd0, 2'd0, 2'd0, 4'h7, 0);
        run_cmd(1'b1, ALU_ADD, 2'd1, 2'd0, 2'd0, 2'd0, 4'h2, 0);
        run_cmd(1'b1, ALU_ADD, 2'd2, 2'd0, 2'd0, 2'd0, 4'hC, 0);
        run_cmd(1'b1, ALU_ADD, 2'd3, 2'd0, 2'd0, 2'd0, 4'h9, 0);
        @(negedge clk);
        bus.cmd_load = 1'b0; bus.cmd_op = ALU_SUB; bus.cmd_dst = 2'd0;
        bus.cmd_src_a = 2'd1; bus.cmd_src_b = 2'd2; bus.cmd_cnt = 2'd3;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) regs_m[i] = 4'h0;
        #1;
        tests_run++;
        if ({alu_a, alu_b, alu_opcode} !== 11'd0 || bus.rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL midexec_reset_outputs: got a=%h b=%h op=%h rv=%b want 0", alu_a, alu_b, alu_opcode, bus.rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL midexec_release: got rdy=%b rv=%b want 1 0", bus.cmd_ready, bus.rsp_valid);
        end
        for (int r = 0; r < 4; r++) begin
            readback(2'(r));
            tests_run++;
            if (obs_d !== 4'h0) begin tests_failed++; $display("FAIL midexec_r%0d_cleared: got %h want 0", r, obs_d); end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_load_sub();
        test_sub_borrow();
        test_shl_iter();
        test_add_iter();
        test_backpressure();
        test_random();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
